rps_match_driver: RTL and testbench
===================================

Name: rps_match_driver

Overview:
- Initiator side of the two-player rock-paper-scissors match core.
- Takes a match configuration and a stream of move pairs over a valid/ready handshake, and generates the core's `inizia`/`primo`/`secondo` stimulus with correct timing.
- Samples the core's `manche`/`partita` results and keeps per-match statistics.
- Reports the final winner to the controlling logic.

Parameters:
- `TIMEOUT`, default 4: cycles to wait in DRAIN for `partita` != 00 before declaring a timeout.
- `CW`, default 4: width of the statistic counters. Counters saturate at 2^CW-1.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  start-match pulse. Honoured only in IDLE.
- `cfg`  in  4  {cfg_p[1:0], cfg_s[1:0]}; max rounds = cfg_p + cfg_s + 4, range 4..10.
- `mv_valid`  in  1  move pair available.
- `mv_p1`  in  2  player-1 move: 01, 10, 11 (00 = null).
- `mv_p2`  in  2  player-2 move, same encoding.
- `mv_ready`  out  1  driver accepts a move pair this cycle.
- `inizia`  out  1  to core: configuration strobe.
- `primo`  out  2  to core: player-1 field.
- `secondo`  out  2  to core: player-2 field.
- `manche`  in  2  from core: 00 none/invalid, 01 P1 round, 10 P2 round, 11 draw.
- `partita`  in  2  from core: 00 running, 01 P1 wins, 10 P2 wins, 11 tie/abort.
- `busy`  out  1  match in progress (not IDLE).
- `done`  out  1  one-cycle pulse on match end.
- `winner`  out  2  latched final `partita` value. 00 if timed out.
- `timeout`  out  1  latched: DRAIN expired without `partita` != 00.
- `wins_p1`  out  CW  count of `manche` = 01.
- `wins_p2`  out  CW  count of `manche` = 10.
- `draws`  out  CW  count of `manche` = 11.
- `rejected`  out  CW  count of sampled `manche` = 00.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - All outputs and counters go to 0, including `inizia`=0 and `primo`=`secondo`=00.
  - Reset mid-match abandons the match; no `done` pulse.
- IDLE:
  - Drives `primo`=`secondo`=00 and `inizia`=0.
  - On `start`=1:
    - latch `cfg`;
    - max_rounds = cfg_p + cfg_s + 4, computed 4 bits wide;
    - clear all counters, `winner` and `timeout`;
    - go to INIT.
- INIT (exactly 1 cycle): `inizia`=1, `primo`=cfg_p, `secondo`=cfg_s. Next state is DRIVE.
- DRIVE:
  - `mv_ready`=1; fields stay 00.
  - On `mv_valid` & `mv_ready`, load `primo`/`secondo` with the move pair and go to PRESENT.
  - No timeout while waiting for moves.
- PRESENT (exactly 1 cycle):
  - The move is held on `primo`/`secondo` for this one cycle only; the core evaluates it at the closing edge.
  - Fields return to 00 at that edge.
  - Next state is SAMPLE.
  - Rationale: the core re-evaluates every clock, and the 00/00 idle pair always yields `manche`=00, so it is never counted.
- SAMPLE (1 cycle):
  - Reads `manche` and increments the matching counter.
  - Valid rounds are 01, 10 and 11. rounds_done increments on a valid round.
  - If `partita` != 00 in this cycle: latch `winner`, go to END.
  - Else if rounds_done == max_rounds: go to DRAIN.
  - Else: go to DRIVE.
- DRAIN:
  - Fields stay 00; a counter runs for up to `TIMEOUT` cycles.
  - On the first cycle with `partita` != 00: latch `winner`, go to END.
  - On expiry: `timeout`=1, `winner`=00, go to END.
- END (1 cycle): `done`=1, then go to IDLE. Counters and `winner` hold until the next `start`.
- `start` in any state other than IDLE is ignored.
- `mv_ready` is 0 outside DRIVE.
- A null move (00) from either player is accepted and presented. The core returns 00, so `rejected` increments.
- A repeated winning move is also rejected by the core and likewise counted in `rejected`.
- Priority when `partita` != 00 and rounds_done == max_rounds in the same SAMPLE cycle: END wins over DRAIN.
- Fixed latencies:
  - `start` to `inizia`: 1 cycle.
  - Move accept to sampled result: 2 cycles.
  - Minimum per round: 3 cycles (DRIVE, PRESENT, SAMPLE).

Test Plan:
- Reset during PRESENT with `primo`=01 → next cycle `primo`=00, `busy`=0, counters 0, no `done`.
- `start`, `cfg`=0000 (max 4); core model returns 01,01,01,01 → `wins_p1`=4, DRAIN entered, `partita`=01 after 1 cycle → `winner`=01, `done` pulses once, `timeout`=0.
- `cfg`=1111 (max 10); moves alternate so core returns 10,11,00,10 and `partita`=10 at 4th SAMPLE → `wins_p2`=2, `draws`=1, `rejected`=1, `winner`=10, END without DRAIN.
- Null move pair 00/00 → presented for exactly 1 cycle, `rejected`=1, rounds_done unchanged.
- `start` pulsed while in DRIVE → ignored, `cfg` latch unchanged, no second `inizia`.
- Core never raises `partita` after 4 rounds, `TIMEOUT`=4 → 4 DRAIN cycles, then `timeout`=1, `winner`=00, `done`=1.

Source files
------------

// File: rtl/rps_match_driver.sv
// Initiator for the two-player rock-paper-scissors match core: sequences config and
// move pairs onto inizia/primo/secondo, samples manche/partita and keeps match statistics.
module rps_match_driver #(
    parameter int TIMEOUT = 4,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [3:0]    cfg,
    input  logic          mv_valid,
    input  logic [1:0]    mv_p1,
    input  logic [1:0]    mv_p2,
    output logic          mv_ready,
    output logic          inizia,
    output logic [1:0]    primo,
    output logic [1:0]    secondo,
    input  logic [1:0]    manche,
    input  logic [1:0]    partita,
    output logic          busy,
    output logic          done,
    output logic [1:0]    winner,
    output logic          timeout,
    output logic [CW-1:0] wins_p1,
    output logic [CW-1:0] wins_p2,
    output logic [CW-1:0] draws,
    output logic [CW-1:0] rejected
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_DRIVE, S_PRESENT, S_SAMPLE, S_DRAIN, S_END
    } state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t         state, state_n;
    logic [3:0]     cfg_q;
    logic [3:0]     max_rounds;
    logic [3:0]     rounds_done;
    logic [3:0]     rounds_inc;
    logic [1:0]     mv_p1_q, mv_p2_q;
    logic [TW-1:0]  drain_cnt;
    logic           round_valid;
    logic           drain_last;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    assign round_valid = (manche != 2'b00);
    assign rounds_inc  = rounds_done + {3'b000, round_valid};
    assign drain_last  = (drain_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Fields are decoded from state so the move lives on primo/secondo for PRESENT only.
    always_comb begin
        state_n  = state;
        mv_ready = 1'b0;
        inizia   = 1'b0;
        primo    = 2'b00;
        secondo  = 2'b00;
        done     = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE:    if (start) state_n = S_INIT;
            S_INIT: begin
                inizia  = 1'b1;
                primo   = cfg_q[3:2];
                secondo = cfg_q[1:0];
                state_n = S_DRIVE;
            end
            S_DRIVE: begin
                mv_ready = 1'b1;
                if (mv_valid) state_n = S_PRESENT;
            end
            S_PRESENT: begin
                primo   = mv_p1_q;
                secondo = mv_p2_q;
                state_n = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (partita != 2'b00)              state_n = S_END;
                else if (rounds_inc == max_rounds) state_n = S_DRAIN;
                else                               state_n = S_DRIVE;
            end
            S_DRAIN:   if (partita != 2'b00 || drain_last) state_n = S_END;
            S_END: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q       <= '0;
            max_rounds  <= '0;
            rounds_done <= '0;
            mv_p1_q     <= '0;
            mv_p2_q     <= '0;
            drain_cnt   <= '0;
            winner      <= '0;
            timeout     <= 1'b0;
            wins_p1     <= '0;
            wins_p2     <= '0;
            draws       <= '0;
            rejected    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cfg_q       <= cfg;
                    max_rounds  <= {2'b00, cfg[3:2]} + {2'b00, cfg[1:0]} + 4'd4;
                    rounds_done <= '0;
                    winner      <= '0;
                    timeout     <= 1'b0;
                    wins_p1     <= '0;
                    wins_p2     <= '0;
                    draws       <= '0;
                    rejected    <= '0;
                end
                S_DRIVE: if (mv_valid) begin
                    mv_p1_q <= mv_p1;
                    mv_p2_q <= mv_p2;
                end
                S_SAMPLE: begin
                    case (manche)
                        2'b01:   wins_p1  <= sat_inc(wins_p1);
                        2'b10:   wins_p2  <= sat_inc(wins_p2);
                        2'b11:   draws    <= sat_inc(draws);
                        default: rejected <= sat_inc(rejected);
                    endcase
                    rounds_done <= rounds_inc;
                    drain_cnt   <= '0;
                    if (partita != 2'b00) winner <= partita;
                end
                S_DRAIN: begin
                    if (partita != 2'b00) begin
                        winner <= partita;
                    end else if (drain_last) begin
                        timeout <= 1'b1;
                        winner  <= 2'b00;
                    end else begin
                        drain_cnt <= drain_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rps_match_driver.sv
// Directed bench for rps_match_driver; the bench plays the match core by driving manche/partita.
module tb_rps_match_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] cfg;
    logic       mv_valid;
    logic [1:0] mv_p1, mv_p2;
    logic       mv_ready;
    logic       inizia;
    logic [1:0] primo, secondo;
    logic [1:0] manche, partita;
    logic       busy, done;
    logic [1:0] winner;
    logic       timeout;
    logic [3:0] wins_p1, wins_p2, draws, rejected;

    int total  = 0;
    int passed = 0;

    rps_match_driver #(.TIMEOUT(4), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg(cfg),
        .mv_valid(mv_valid), .mv_p1(mv_p1), .mv_p2(mv_p2), .mv_ready(mv_ready),
        .inizia(inizia), .primo(primo), .secondo(secondo),
        .manche(manche), .partita(partita),
        .busy(busy), .done(done), .winner(winner), .timeout(timeout),
        .wins_p1(wins_p1), .wins_p2(wins_p2), .draws(draws), .rejected(rejected)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (mv_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", mv_ready, 1);
    endtask

    // One round: offer the pair in DRIVE, check it in PRESENT, answer as the core in SAMPLE.
    task automatic round(input logic [1:0] p1, input logic [1:0] p2,
                         input logic [1:0] m, input logic [1:0] pt);
        wait_ready();
        mv_valid = 1'b1; mv_p1 = p1; mv_p2 = p2;
        @(negedge clk);
        mv_valid = 1'b0; mv_p1 = 2'b00; mv_p2 = 2'b00;
        check("present_primo", primo, p1);
        check("present_secondo", secondo, p2);
        @(negedge clk);
        check("sample_primo", primo, 0);
        check("sample_secondo", secondo, 0);
        manche = m; partita = pt;
        @(negedge clk);
        manche = 2'b00;
    endtask

    task automatic begin_match(input logic [3:0] c);
        cfg = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cfg = 4'b0000;
        check("init_inizia", inizia, 1);
        check("init_primo", primo, c[3:2]);
        check("init_secondo", secondo, c[1:0]);
        check("init_ready", mv_ready, 0);
        @(negedge clk);
        check("drive_inizia", inizia, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg = 4'b0000;
        mv_valid = 1'b0; mv_p1 = 2'b00; mv_p2 = 2'b00;
        manche = 2'b00; partita = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_fields", {inizia, primo, secondo}, 0);
        check("rst_ready", mv_ready, 0);
        check("rst_counters", {wins_p1, wins_p2, draws, rejected}, 0);
        check("rst_status", {done, winner, timeout}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Match A: max 4 rounds, P1 wins all four, core declares P1 during DRAIN
        begin_match(4'b0000);
        round(2'b01, 2'b11, 2'b01, 2'b00);
        check("a_wins_p1_1", wins_p1, 1);
        // start while DRIVE must not re-latch cfg (1111 would stretch the match to 10 rounds)
        cfg = 4'b1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cfg = 4'b0000;
        check("a_ign_inizia", inizia, 0);
        check("a_ign_ready", mv_ready, 1);
        round(2'b10, 2'b01, 2'b01, 2'b00);
        round(2'b11, 2'b10, 2'b01, 2'b00);
        round(2'b01, 2'b11, 2'b01, 2'b00);
        check("a_drain_ready", mv_ready, 0);
        check("a_drain_busy", busy, 1);
        check("a_drain_done", done, 0);
        check("a_wins_p1", wins_p1, 4);
        @(negedge clk);
        partita = 2'b01;
        @(negedge clk);
        partita = 2'b00;
        check("a_done", done, 1);
        check("a_winner", winner, 2'b01);
        check("a_timeout", timeout, 0);
        @(negedge clk);
        check("a_done_once", done, 0);
        check("a_idle", busy, 0);
        check("a_hold_wins", wins_p1, 4);

        // Match B: max 10 rounds, P2 wins at the 4th sample without DRAIN
        begin_match(4'b1111);
        round(2'b10, 2'b01, 2'b10, 2'b00);
        round(2'b01, 2'b01, 2'b11, 2'b00);
        round(2'b00, 2'b00, 2'b00, 2'b00);
        check("b_rejected_null", rejected, 1);
        check("b_wins_p1_clr", wins_p1, 0);
        round(2'b10, 2'b01, 2'b10, 2'b10);
        partita = 2'b00;
        check("b_done", done, 1);
        check("b_winner", winner, 2'b10);
        check("b_stats", {wins_p2, draws, rejected}, {4'd2, 4'd1, 4'd1});
        check("b_timeout", timeout, 0);
        @(negedge clk);
        check("b_idle", busy, 0);

        // Match C: core never finishes, DRAIN expires after 4 cycles
        begin_match(4'b0000);
        for (int i = 0; i < 4; i++) round(2'b01, 2'b01, 2'b11, 2'b00);
        check("c_draws", draws, 4);
        for (int i = 0; i < 4; i++) begin
            check("c_drain_done", done, 0);
            check("c_drain_busy", busy, 1);
            @(negedge clk);
        end
        check("c_done", done, 1);
        check("c_timeout", timeout, 1);
        check("c_winner", winner, 0);
        @(negedge clk);
        check("c_idle", busy, 0);
        check("c_timeout_hold", timeout, 1);

        // Match D: asynchronous reset while a move is presented
        begin_match(4'b0000);
        round(2'b01, 2'b11, 2'b01, 2'b00);
        check("d_wins_p1", wins_p1, 1);
        wait_ready();
        mv_valid = 1'b1; mv_p1 = 2'b01; mv_p2 = 2'b10;
        @(negedge clk);
        mv_valid = 1'b0; mv_p1 = 2'b00; mv_p2 = 2'b00;
        check("d_present", primo, 2'b01);
        #1 rst_n = 1'b0;
        #1;
        check("d_rst_primo", primo, 0);
        check("d_rst_busy", busy, 0);
        check("d_rst_counters", {wins_p1, wins_p2, draws, rejected}, 0);
        @(negedge clk);
        check("d_rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("d_after_done", done, 0);
        check("d_after_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
